dma_descriptor_sequencer: RTL
=============================

// Module: dma_descriptor_sequencer
// PURPOSE
// - Queues DMA descriptors pushed by the CPU custom instruction and programs ramDmaCi_new through its CI port.
// - Writes each descriptor's registers in order, starts the transfer, then polls status until the transfer ends.
// - Arbitrates the single DMA CI port between this sequencer and CPU direct (pass-through) CI accesses.
// - Sits between the OpenRISC CI bus and the DMA block, so the CPU no longer busy-waits on DMA status.
// PARAMETERS
// - customId       8'hfc  ciN value for sequencer commands
// - customIdDirect 8'hfe  ciN value forwarded unchanged to the DMA (pass-through)
// - DEPTH          4      descriptor FIFO entries; must be a power of 2
// - POLL_INTERVAL  4      idle cycles between DMA status reads (>=2)
// PORTS
// - clock         in   1   system clock
// - reset         in   1   asynchronous, active-high
// - start         in   1   CPU CI strobe
// - ciN           in   8   CPU CI id
// - valueA        in   32  CPU operand A
// - valueB        in   32  CPU operand B
// - done          out  1   CPU CI completion
// - result        out  32  CPU CI result
// - dmaCiStart    out  1   DMA CI strobe
// - dmaCiN        out  8   always customIdDirect
// - dmaCiValueA   out  32  DMA operand A (register select in [12:9])
// - dmaCiValueB   out  32  DMA operand B
// - dmaCiDone     in   1   DMA CI completion
// - dmaCiResult   in   32  DMA CI result (status: bit0 busy, bit1 bus error)
// - irq           out  1   1-cycle pulse per completed descriptor
// BEHAVIOUR
// - Reset (async): FIFO empty; FSM IDLE; counters 0; errSticky 0. Outputs done, result, dmaCiStart, dmaCiValueA, dmaCiValueB and irq are all 0.
// - Sequencer commands (start && ciN==customId) are selected by valueA[2:0]. All complete combinationally in the same cycle (done=1).
//   - 0: stage busAddr <= valueB; result=0.
//   - 1: push {busAddr, memAddr=valueB[8:0], blockSize=valueB[18:9], burst=valueB[26:19], dir=valueB[27]}.
//     result=1 if accepted; result=0 if the FIFO is full (nothing written).
//   - 2: read status. result={errSticky, FSM!=IDLE, fill[5:0], completed[15:0]}, zero-extended to 32 bits.
//   - 3: flush queued (not-yet-started) descriptors; the active descriptor finishes normally. Clear errSticky. result=0.
//   - 4-7: done=1, result=0, no effect.
// - Pass-through (ciN==customIdDirect): forwarded to the DMA only in IDLE or during a POLL_WAIT gap.
//   - Otherwise done stays 0 (the CPU stalls) until such a slot arrives.
//   - done and result mirror dmaCiDone and dmaCiResult.
// - DMA CI handshake: hold dmaCiStart and operands stable until the cycle dmaCiDone=1, then drop dmaCiStart for at least 1 cycle.
// - FSM states and actions:
//   - IDLE: if FIFO not empty, go to W_BUS.
//   - W_BUS: reg 3 <= busAddr.
//   - W_MEM: reg 5 <= memAddr.
//   - W_BLK: reg 7 <= blockSize.
//   - W_BST: reg 9 <= burst.
//   - W_CTL: reg 11 <= dir ? 2 : 1.
//   - POLL_WAIT: count POLL_INTERVAL cycles, then POLL.
//   - POLL: read reg 10.
//     - busy=1: go to POLL_WAIT.
//     - busy=0 and bit1=0: pop FIFO, completed++ (wraps at 16 bits), pulse irq, go to IDLE.
//     - busy=0 and bit1=1: pop FIFO, set errSticky, no irq, no count, go to IDLE.
//   - Each W_* state and POLL advance only on dmaCiDone.
// - Register select: dmaCiValueA={19'b0, sel[3:0], 9'b0}.
// - Push and pop in the same cycle with the FIFO full: the push is accepted and fill is unchanged.
// - Flush and pop in the same cycle: the FIFO ends empty and the active pop still counts.
// - Arbitration: the pending pass-through wins over the sequencer poll issued on the same cycle of POLL_WAIT expiry; the poll waits.
// STRUCTURE
// - Shared package dma_seq_pkg: DMA register-select constants (3,5,7,9,10,11), control codes 1/2, FSM state enum, descriptor struct (32+9+10+8+1 bits).
// - Sub-module dma_desc_fifo: synchronous DEPTH x 60-bit FIFO with full/empty/fill outputs and flush input.
// TESTING
// - Push 1 descriptor (bus 0x100, mem 0, blk 64, burst 7, dir 0) with a model DMA busy 3 polls -> register writes 3,5,7,9,11 in order with those values; irq pulses once; completed=1.
// - Push DEPTH+1 descriptors while the DMA is busy -> 5th push returns result=0; fill=4; all 4 complete in FIFO order.
// - Model returns status bit1=1 -> errSticky=1; completed unchanged; next descriptor still runs; flush (op 3) clears errSticky.
// - Pass-through read of reg 4 during W_MEM -> done held 0 until POLL_WAIT, then returns the DMA value; the sequencer sequence is not corrupted.
// - Assert reset during POLL -> all outputs 0 immediately; FIFO empty; after release the FSM is IDLE and dmaCiStart is 0.
// - Flush with 3 queued and 1 active -> active completes (completed+1); the queue ends empty; FSM returns to IDLE.

Source files
------------

// File: rtl/dma_seq_pkg.sv
// Shared types for the DMA descriptor sequencer:
// DMA register map, FSM states and the queued descriptor layout.
package dma_seq_pkg;

  localparam logic [3:0] REG_BUS  = 4'd3;
  localparam logic [3:0] REG_MEM  = 4'd5;
  localparam logic [3:0] REG_BLK  = 4'd7;
  localparam logic [3:0] REG_BST  = 4'd9;
  localparam logic [3:0] REG_STAT = 4'd10;
  localparam logic [3:0] REG_CTL  = 4'd11;

  localparam logic [31:0] CTL_DIR0 = 32'd1;
  localparam logic [31:0] CTL_DIR1 = 32'd2;

  typedef enum logic [2:0] {
    IDLE,
    W_BUS,
    W_MEM,
    W_BLK,
    W_BST,
    W_CTL,
    POLL_WAIT,
    POLL
  } seqState_t;

  typedef struct packed {
    logic [31:0] busAddr;
    logic [8:0]  memAddr;
    logic [9:0]  blockSize;
    logic [7:0]  burst;
    logic        dir;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

  function automatic logic [31:0] selWord(input logic [3:0] sel);
    return {19'b0, sel, 9'b0};
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Descriptor FIFO with flush; a pop is honoured before a push
// so a full FIFO still accepts a write when it drains in the same cycle.
module dma_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 60
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full   = fill == FW'(DEPTH);
  assign empty  = fill == '0;
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush && !flush) mem[wrPtr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fill  <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fill  <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      fill <= fill + FW'(doPush) - FW'(doPop);
    end
  end

endmodule

// File: rtl/dma_descriptor_sequencer.sv
// Queues CPU-pushed DMA descriptors, programs the DMA over its CI port,
// polls for completion and shares that port with CPU pass-through accesses.
module dma_descriptor_sequencer
  import dma_seq_pkg::*;
#(
  parameter logic [7:0] customId       = 8'hfc,
  parameter logic [7:0] customIdDirect = 8'hfe,
  parameter int         DEPTH          = 4,
  parameter int         POLL_INTERVAL  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        dmaCiStart,
  output logic [7:0]  dmaCiN,
  output logic [31:0] dmaCiValueA,
  output logic [31:0] dmaCiValueB,
  input  logic        dmaCiDone,
  input  logic [31:0] dmaCiResult,
  output logic        irq
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(POLL_INTERVAL + 1);
  localparam logic [CW-1:0] PMAX = CW'(POLL_INTERVAL - 1);

  seqState_t     state;
  seqState_t     nextW;
  desc_t         cur;
  desc_t         pushDesc;
  desc_t         fifoHead;
  logic [31:0]   busAddr;
  logic [15:0]   completed;
  logic          errSticky;
  logic          activeInFifo;
  logic          ptActive;
  logic [CW-1:0] pollCnt;
  logic [3:0]    reqSel;
  logic [31:0]   reqVal;
  logic [FW-1:0] fifoFill;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [2:0]    op;
  logic          seqCmd;
  logic          directReq;
  logic          ptLaunch;
  logic          finish;
  logic          fifoPop;
  logic          doPush;
  logic          doFlush;
  logic          pushOk;
  logic [23:0]   status;

  assign dmaCiN    = customIdDirect;
  assign op        = valueA[2:0];
  assign seqCmd    = start && (ciN == customId);
  assign directReq = start && (ciN == customIdDirect);
  assign ptLaunch  = directReq && !ptActive && !dmaCiStart
                     && (state == IDLE || state == POLL_WAIT);
  assign finish    = (state == POLL) && dmaCiStart && dmaCiDone
                     && !dmaCiResult[0];
  assign fifoPop   = finish && activeInFifo;
  assign doPush    = seqCmd && (op == 3'd1);
  assign doFlush   = seqCmd && (op == 3'd3);
  assign pushOk    = !fifoFull || fifoPop;
  assign status    = {errSticky, state != IDLE, 6'(fifoFill), completed};

  assign pushDesc = '{
    busAddr:   busAddr,
    memAddr:   valueB[8:0],
    blockSize: valueB[18:9],
    burst:     valueB[26:19],
    dir:       valueB[27]
  };

  dma_desc_fifo #(
    .DEPTH (DEPTH),
    .W     (DESC_W)
  ) uFifo (
    .clock (clock),
    .reset (reset),
    .push  (doPush),
    .pop   (fifoPop),
    .flush (doFlush),
    .din   (pushDesc),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .fill  (fifoFill)
  );

  always_comb begin
    done   = 1'b0;
    result = '0;
    if (ptActive) begin
      done   = dmaCiDone;
      result = dmaCiDone ? dmaCiResult : '0;
    end else if (seqCmd) begin
      done = 1'b1;
      case (op)
        3'd1:    result = {31'b0, pushOk};
        3'd2:    result = {8'b0, status};
        default: result = '0;
      endcase
    end
  end

  always_comb begin
    reqSel = REG_STAT;
    reqVal = '0;
    nextW  = POLL_WAIT;
    case (state)
      W_BUS: begin
        reqSel = REG_BUS;
        reqVal = cur.busAddr;
        nextW  = W_MEM;
      end
      W_MEM: begin
        reqSel = REG_MEM;
        reqVal = {23'b0, cur.memAddr};
        nextW  = W_BLK;
      end
      W_BLK: begin
        reqSel = REG_BLK;
        reqVal = {22'b0, cur.blockSize};
        nextW  = W_BST;
      end
      W_BST: begin
        reqSel = REG_BST;
        reqVal = {24'b0, cur.burst};
        nextW  = W_CTL;
      end
      W_CTL: begin
        reqSel = REG_CTL;
        reqVal = cur.dir ? CTL_DIR1 : CTL_DIR0;
        nextW  = POLL_WAIT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur          <= '0;
      busAddr      <= '0;
      completed    <= '0;
      errSticky    <= 1'b0;
      activeInFifo <= 1'b0;
      ptActive     <= 1'b0;
      pollCnt      <= '0;
      dmaCiStart   <= 1'b0;
      dmaCiValueA  <= '0;
      dmaCiValueB  <= '0;
      irq          <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (seqCmd && op == 3'd0) busAddr <= valueB;

      // Pass-through only ever runs while the FSM sits in IDLE/POLL_WAIT
      if (ptLaunch) begin
        ptActive    <= 1'b1;
        dmaCiStart  <= 1'b1;
        dmaCiValueA <= valueA;
        dmaCiValueB <= valueB;
      end else if (ptActive && dmaCiDone) begin
        ptActive   <= 1'b0;
        dmaCiStart <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!fifoEmpty && !ptActive && !directReq) begin
            state        <= W_BUS;
            cur          <= fifoHead;
            activeInFifo <= 1'b1;
          end
        end
        POLL_WAIT: begin
          if (pollCnt != PMAX) pollCnt <= pollCnt + CW'(1);
          if (pollCnt == PMAX && !ptActive && !directReq
              && !dmaCiStart)
            state <= POLL;
        end
        W_BUS, W_MEM, W_BLK, W_BST, W_CTL, POLL: begin
          if (!dmaCiStart) begin
            dmaCiStart  <= 1'b1;
            dmaCiValueA <= selWord(reqSel);
            dmaCiValueB <= reqVal;
          end else if (dmaCiDone) begin
            dmaCiStart <= 1'b0;
            pollCnt    <= '0;
            if (state != POLL) begin
              state <= nextW;
            end else if (dmaCiResult[0]) begin
              state <= POLL_WAIT;
            end else begin
              state        <= IDLE;
              activeInFifo <= 1'b0;
              if (dmaCiResult[1]) begin
                errSticky <= 1'b1;
              end else begin
                completed <= completed + 16'd1;
                irq       <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A flush drops the head too, so the active one must not pop later
      if (doFlush) begin
        activeInFifo <= 1'b0;
        errSticky    <= 1'b0;
      end
    end
  end

endmodule
